// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for the boot loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        out_ready;
  logic        out_imem_wrt;
  logic [31:0] out_imem_addr;
  logic [31:0] out_imem_data;
  logic        out_cpu_hold;
  logic        out_done;
  logic        out_error;
  logic [15:0] out_count;

  modport master (
    output in_valid, in_byte,
    input  out_ready, out_imem_wrt, out_imem_addr, out_imem_data,
           out_cpu_hold, out_done, out_error, out_count
  );

  modport slave (
    input  in_valid, in_byte,
    output out_ready, out_imem_wrt, out_imem_addr, out_imem_data,
           out_cpu_hold, out_done, out_error, out_count
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a length-prefixed, XOR-checksummed byte stream into
// big-endian instruction words and holds the CPU in reset until the image verifies.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] count_q, count_d;
  logic        wrt_q, wrt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        hold_q, hold_d;

  logic ready_c;
  logic accept_c;

  assign ready_c  = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == DATA)   || (state_q == CSUM);
  assign accept_c = bus.in_valid && ready_c;

  // Next-state and output decode; count_q doubles as the number of words received.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    count_d = count_q;
    wrt_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    error_d = error_q;
    hold_d  = hold_q;

    case (state_q)
      LEN_HI: begin
        if (accept_c) begin
          len_d   = {bus.in_byte, len_q[7:0]};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept_c) begin
          len_d = {len_q[15:8], bus.in_byte};
          if (32'(len_d) > MAX_WORDS) begin
            state_d = ERROR;
            error_d = 1'b1;
            hold_d  = 1'b1;
          end else if (len_d == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept_c) begin
          csum_d = csum_q ^ bus.in_byte;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            wrt_d   = 1'b1;
            addr_d  = 32'(count_q[ADDR_WIDTH-1:0]);
            data_d  = {word_q, bus.in_byte};
            count_d = count_q + 16'd1;
            word_d  = 24'd0;
            if (count_d == len_q) begin
              state_d = CSUM;
            end
          end else begin
            word_d = {word_q[15:0], bus.in_byte};
          end
        end
      end
      CSUM: begin
        if (accept_c) begin
          if (bus.in_byte == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end
      DONE, ERROR: begin
      end
      default: begin
        state_d = LEN_HI;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LEN_HI;
      len_q   <= 16'd0;
      word_q  <= 24'd0;
      idx_q   <= 2'd0;
      csum_q  <= 8'd0;
      count_q <= 16'd0;
      wrt_q   <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      count_q <= count_d;
      wrt_q   <= wrt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.out_ready     = ready_c;
  assign bus.out_imem_wrt  = wrt_q;
  assign bus.out_imem_addr = addr_q;
  assign bus.out_imem_data = data_q;
  assign bus.out_cpu_hold  = hold_q;
  assign bus.out_done      = done_q;
  assign bus.out_error     = error_q;
  assign bus.out_count     = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, bad checksum, zero length, oversize,
// gapped handshake and reset mid-word, with a write-strobe log for address/data checks.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  stim[$];

  imem_loader_if bus();

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Log every write strobe and watch the done/error exclusivity invariant.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_imem_wrt === 1'b1) begin
        wr_addr.push_back(bus.out_imem_addr);
        wr_data.push_back(bus.out_imem_data);
      end
      checks++;
      assert (!(bus.out_done === 1'b1 && bus.out_error === 1'b1)) else begin
        errors++;
        $error("FAIL done_error_excl: observed done=%b error=%b required not both 1",
               bus.out_done, bus.out_error);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
  endtask

  // gap_after < 0 disables the long gap; toggle inserts one idle cycle after every byte.
  task automatic send_stim(input bit toggle, input int gap_after);
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i]);
      if (toggle) idle(1);
      if (i == gap_after) idle(5);
    end
    idle(2);
  endtask

  task automatic check_nominal(input string pfx);
    check({pfx, "_nwr"},   32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({pfx, "_a0"}, wr_addr[0], 32'd0);
      check({pfx, "_d0"}, wr_data[0], 32'h1234_5678);
      check({pfx, "_a1"}, wr_addr[1], 32'd1);
      check({pfx, "_d1"}, wr_data[1], 32'hDEAD_BEEF);
    end
    check({pfx, "_count"}, 32'(bus.out_count), 32'd2);
    check({pfx, "_done"},  32'(bus.out_done), 32'd1);
    check({pfx, "_error"}, 32'(bus.out_error), 32'd0);
    check({pfx, "_hold"},  32'(bus.out_cpu_hold), 32'd0);
    check({pfx, "_ready"}, 32'(bus.out_ready), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    do_reset();
    mon_en = 1'b1;

    // Reset state
    check("rst_ready", 32'(bus.out_ready), 32'd1);
    check("rst_wrt",   32'(bus.out_imem_wrt), 32'd0);
    check("rst_addr",  bus.out_imem_addr, 32'd0);
    check("rst_data",  bus.out_imem_data, 32'd0);
    check("rst_hold",  32'(bus.out_cpu_hold), 32'd1);
    check("rst_done",  32'(bus.out_done), 32'd0);
    check("rst_error", 32'(bus.out_error), 32'd0);
    check("rst_count", 32'(bus.out_count), 32'd0);

    // Nominal load, valid held high, with a strobe-latency probe after the 4th data byte
    bus.in_valid = 1'b1;
    bus.in_byte = 8'h00; @(posedge clk); #1;
    bus.in_byte = 8'h02; @(posedge clk); #1;
    bus.in_byte = 8'h12; @(posedge clk); #1;
    bus.in_byte = 8'h34; @(posedge clk); #1;
    bus.in_byte = 8'h56; @(posedge clk); #1;
    check("nom_prewrt", 32'(bus.out_imem_wrt), 32'd0);
    bus.in_byte = 8'h78; @(posedge clk); #1;
    check("nom_strobe", 32'(bus.out_imem_wrt), 32'd1);
    check("nom_saddr",  bus.out_imem_addr, 32'd0);
    check("nom_sdata",  bus.out_imem_data, 32'h1234_5678);
    check("nom_scount", 32'(bus.out_count), 32'd1);
    bus.in_byte = 8'hDE; @(posedge clk); #1;
    check("nom_onecyc", 32'(bus.out_imem_wrt), 32'd0);
    bus.in_byte = 8'hAD; @(posedge clk); #1;
    bus.in_byte = 8'hBE; @(posedge clk); #1;
    bus.in_byte = 8'hEF; @(posedge clk); #1;
    check("nom_hold_pre", 32'(bus.out_cpu_hold), 32'd1);
    bus.in_byte = 8'h2A; @(posedge clk); #1;
    bus.in_valid = 1'b0;
    idle(2);
    check_nominal("nom");

    // Bad checksum
    do_reset();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2B};
    send_stim(1'b0, -1);
    check("bad_nwr",   32'(wr_addr.size()), 32'd2);
    check("bad_error", 32'(bus.out_error), 32'd1);
    check("bad_done",  32'(bus.out_done), 32'd0);
    check("bad_hold",  32'(bus.out_cpu_hold), 32'd1);
    check("bad_ready", 32'(bus.out_ready), 32'd0);
    check("bad_count", 32'(bus.out_count), 32'd2);

    // Zero length
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00};
    send_stim(1'b0, -1);
    check("zero_nwr",   32'(wr_addr.size()), 32'd0);
    check("zero_done",  32'(bus.out_done), 32'd1);
    check("zero_count", 32'(bus.out_count), 32'd0);
    check("zero_hold",  32'(bus.out_cpu_hold), 32'd0);

    // Oversize length (257 > 256); further bytes must be refused
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    check("ovr_error", 32'(bus.out_error), 32'd1);
    check("ovr_ready", 32'(bus.out_ready), 32'd0);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_stim(1'b0, -1);
    check("ovr_nwr",   32'(wr_addr.size()), 32'd0);
    check("ovr_count", 32'(bus.out_count), 32'd0);
    check("ovr_done",  32'(bus.out_done), 32'd0);
    check("ovr_hold",  32'(bus.out_cpu_hold), 32'd1);

    // Exactly MAX_WORDS is legal: length 256 must enter DATA, not ERROR
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    check("max_error", 32'(bus.out_error), 32'd0);
    check("max_ready", 32'(bus.out_ready), 32'd1);

    // Gapped handshake: toggled valid plus a 5-cycle gap inside the first word
    do_reset();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
    send_stim(1'b1, 3);
    check_nominal("gap");

    // Reset mid-word, then a fresh one-word stream
    do_reset();
    stim = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_stim(1'b0, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    check("mid_count", 32'(bus.out_count), 32'd0);
    check("mid_hold",  32'(bus.out_cpu_hold), 32'd1);
    check("mid_nwr",   32'(wr_addr.size()), 32'd0);
    check("mid_ready", 32'(bus.out_ready), 32'd1);
    stim = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_stim(1'b0, -1);
    check("mid2_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("mid2_a0", wr_addr[0], 32'd0);
      check("mid2_d0", wr_data[0], 32'hAABB_CCDD);
    end
    check("mid2_done",  32'(bus.out_done), 32'd1);
    check("mid2_count", 32'(bus.out_count), 32'd1);
    check("mid2_hold",  32'(bus.out_cpu_hold), 32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: the write side of the instruction memory that the pipeline fetch stage reads.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory through its write port at consecutive word addresses.
- Holds the CPU in reset until a complete, checksum-verified image has been loaded.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width; maximum image size is MAX_WORDS = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_byte holds a valid stream byte.
- in_byte  in  8  stream byte.
- out_ready  out  1  loader can accept a byte this cycle.
- out_imem_wrt  out  1  one-cycle instruction-memory write strobe.
- out_imem_addr  out  32  word address for the write; zero-extended from ADDR_WIDTH bits.
- out_imem_data  out  32  instruction word to write.
- out_cpu_hold  out  1  holds the CPU/PC in reset while high.
- out_done  out  1  image loaded and verified; sticky.
- out_error  out  1  load failed; sticky.
- out_count  out  16  number of words written so far.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. rst dominates every other input.
- Reset values, after any edge with rst=1:
  - state = LEN_HI
  - out_imem_wrt, out_imem_addr, out_imem_data, out_done, out_error = 0
  - out_count = 0; checksum accumulator = 0; byte index = 0; partial word discarded
  - out_cpu_hold = 1
- Handshake:
  - A byte is accepted on a rising edge when in_valid && out_ready.
  - out_ready is decoded combinationally from state: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in DONE and ERROR.
  - in_valid low means no state change. Gaps of any length are allowed.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes, then one checksum byte.
  - The checksum is the XOR of all data bytes only; length bytes are excluded.
- State machine:
  - LEN_HI: accept byte into len[15:8] -> LEN_LO.
  - LEN_LO: accept byte into len[7:0].
    - If the full length > MAX_WORDS -> ERROR.
    - Else if the length = 0 -> CSUM.
    - Else -> DATA.
  - DATA:
    - Each accepted byte is shifted into the word, first byte -> bits [31:24], and XORed into the checksum.
    - Byte index wraps 3 -> 0.
    - When the 4th byte of a word is accepted, the next cycle drives out_imem_wrt=1 for exactly one cycle, with out_imem_addr = out_count (value before the write) and out_imem_data = the assembled word.
    - out_count increments in the same cycle as the strobe.
    - Leave DATA for CSUM when word N has been received.
    - Write latency: 1 cycle after acceptance of the final byte of the word. Byte acceptance continues during the strobe cycle.
  - CSUM: accept byte.
    - Equal to the accumulator -> DONE.
    - Otherwise -> ERROR.
    - The write of the last word completes no later than the cycle in which CSUM is entered.
  - DONE: out_done=1, out_cpu_hold=0. Terminal until rst. in_valid is ignored.
  - ERROR: out_error=1, out_cpu_hold=1. Terminal until rst. Words already written are not rolled back.
- Invariants:
  - out_done and out_error are never both 1.
  - out_imem_wrt is 0 whenever state is not DATA or CSUM.
  - out_count never exceeds MAX_WORDS.
- Reset mid-load: the partial word, count and checksum are discarded. The next stream is parsed from LEN_HI.

Test Plan:
- Nominal load, ADDR_WIDTH=8, stream 00 02 12 34 56 78 DE AD BE EF 2A (valid held high) -> two write strobes: addr 0 / 0x12345678, then addr 1 / 0xDEADBEEF. Afterwards out_count=2, out_done=1, out_cpu_hold=0, out_ready=0.
- Bad checksum: same stream with final byte 2B -> both writes still occur; out_error=1, out_done=0, out_cpu_hold=1.
- Zero length: stream 00 00 00 -> no write strobes; out_done=1, out_count=0.
- Oversize: stream 01 01 with ADDR_WIDTH=8 (MAX_WORDS=256) -> ERROR entered right after LEN_LO; out_ready=0; no writes; further bytes are not accepted.
- Gapped handshake: nominal stream with in_valid toggling 1/0 every cycle, plus a 5-cycle gap inside word 1 -> writes, addresses, data and final state identical to the nominal case.
- Reset mid-word: rst for 1 cycle after 00 01 12 34 -> out_count=0, out_cpu_hold=1, no write. A following stream 00 01 AA BB CC DD 00 then loads addr 0 = 0xAABBCCDD with out_done=1.
